max11046_emulator: RTL and testbench

Synthesizable device-side model of the MAX11046 8-channel parallel-output ADC. It responds to the CONVST/CS/RD/WR strobes that our ADC controller drives and answers with EOC and a per-channel 16-bit data word on DB. It sits in a loopback test build in place of the physical ADC, so the controller can be exercised in hardware and in simulation with known, self-identifying sample values.

---
 rtl/max11046_pkg.sv | 28 ++
 rtl/max11046_emulator_strobe_sync.sv | 31 +++
 rtl/max11046_emulator.sv | 163 ++++++++++++++++
 tb/tb_max11046_emulator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/max11046_pkg.sv
// Shared types and field positions for the MAX11046 device-side emulator.
// Imported by the strobe synchronizer and the top level.
package max11046_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    READY
  } state_e;

  localparam int NUM_CH_MAX = 8;
  localparam int CH_MSB     = 15;
  localparam int CH_LSB     = 13;
  localparam int CFG_TWOS   = 0;

  // Self-identifying sample: channel in the top bits, frame below.
  function automatic logic [15:0] data_word(
    input logic [2:0]  ch,
    input logic [15:0] frame,
    input logic        twos
  );
    logic [15:0] w;
    w = {ch, frame[CH_LSB-1:0]};
    w[CH_MSB] = w[CH_MSB] ^ twos;
    return w;
  endfunction

endpackage

// File: rtl/max11046_emulator_strobe_sync.sv
// Multi-flop synchronizer with a one-flop edge detector for one strobe.
// Resets to the idle-high level so reset release never looks like an edge.
module strobe_sync #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] chain_q;
  logic             prev_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[DEPTH-2:0], din};
      prev_q  <= chain_q[DEPTH-1];
    end
  end

  assign sync = chain_q[DEPTH-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/max11046_emulator.sv
// Device-side MAX11046 model: answers CONVST/CS/RD/WR with EOC and
// per-channel words {ch_idx, frame_cnt[12:0]} for controller loopback.
module max11046_emulator
  import max11046_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 399,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        convst_n,
  input  logic        cs_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        db_oe,
  output logic        eoc_n,
  output logic        busy,
  output logic [15:0] cfg,
  output logic [15:0] frame_cnt
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [2:0]    LAST_CH  = 3'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("NUM_CH must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (CONV_CYCLES < 1) begin : g_bad_conv
    $error("CONV_CYCLES must be at least 1");
  end

  logic s_convst_n, conv_rise, conv_fall;
  logic s_cs_n, cs_rise, cs_fall;
  logic s_rd_n, rd_rise, rd_fall;
  logic s_wr_n, wr_rise, wr_fall;

  strobe_sync #(.DEPTH(SYNC_STAGES)) u_sync_convst (
    .clock(clock), .rst(rst), .din(convst_n),
    .sync(s_convst_n), .rise(conv_rise), .fall(conv_fall)
  );
  strobe_sync #(.DEPTH(SYNC_STAGES)) u_sync_cs (
    .clock(clock), .rst(rst), .din(cs_n),
    .sync(s_cs_n), .rise(cs_rise), .fall(cs_fall)
  );
  strobe_sync #(.DEPTH(SYNC_STAGES)) u_sync_rd (
    .clock(clock), .rst(rst), .din(rd_n),
    .sync(s_rd_n), .rise(rd_rise), .fall(rd_fall)
  );
  strobe_sync #(.DEPTH(SYNC_STAGES)) u_sync_wr (
    .clock(clock), .rst(rst), .din(wr_n),
    .sync(s_wr_n), .rise(wr_rise), .fall(wr_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, s_convst_n, conv_fall,
                          cs_rise, cs_fall, wr_fall};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ch_q, ch_d;
  logic          eoc_q, eoc_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_q, frame_d;
  logic [15:0]   cfg_q, cfg_d;
  logic          oe_d;
  logic          rd_ok;
  logic          s_wr_n_low;

  assign s_wr_n_low = ~s_wr_n;
  // An active write blocks read decoding as well as the output driver.
  assign rd_ok = ~s_cs_n & ~s_wr_n_low;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    eoc_d   = eoc_q;
    busy_d  = busy_q;
    frame_d = frame_q;
    cfg_d   = cfg_q;
    oe_d    = ~s_cs_n & ~s_rd_n & ~s_wr_n_low;

    unique case (state_q)
      IDLE: begin
        if (conv_rise) begin
          state_d = CONV;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        if (cnt_q == '0) begin
          state_d = READY;
          eoc_d   = 1'b0;
          busy_d  = 1'b0;
          ch_d    = 3'd0;
          frame_d = frame_q + 16'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      READY: begin
        if (conv_rise) begin
          state_d = CONV;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          eoc_d   = 1'b1;
          ch_d    = 3'd0;
        end else begin
          if (rd_ok && rd_fall) eoc_d = 1'b1;
          if (rd_ok && rd_rise) begin
            if (ch_q == LAST_CH) begin
              ch_d    = 3'd0;
              state_d = IDLE;
            end else begin
              ch_d = ch_q + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_rise && !s_cs_n) cfg_d = db_in;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= 3'd0;
      eoc_q   <= 1'b1;
      busy_q  <= 1'b0;
      frame_q <= 16'd0;
      cfg_q   <= 16'd0;
      db_oe   <= 1'b0;
      db_out  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      eoc_q   <= eoc_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      cfg_q   <= cfg_d;
      db_oe   <= oe_d;
      db_out  <= data_word(ch_q, frame_q, cfg_q[CFG_TWOS]);
    end
  end

  assign eoc_n     = eoc_q;
  assign busy      = busy_q;
  assign cfg       = cfg_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_max11046_emulator.sv
// Directed bench for max11046_emulator: conversion timing, readout,
// config write, abort, reset and ignored CONVST.
module tb_max11046_emulator;

  logic        clock = 1'b0;
  logic        rst;
  logic        convst_n, cs_n, rd_n, wr_n;
  logic [15:0] db_in;
  logic [15:0] db_out;
  logic        db_oe, eoc_n, busy;
  logic [15:0] cfg, frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] d;
  logic        oe;

  always #5 clock = ~clock;

  max11046_emulator dut (
    .clock(clock), .rst(rst),
    .convst_n(convst_n), .cs_n(cs_n),
    .rd_n(rd_n), .wr_n(wr_n),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
    .eoc_n(eoc_n), .busy(busy),
    .cfg(cfg), .frame_cnt(frame_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic conv_pulse();
    convst_n = 1'b0;
    tick(10);
    convst_n = 1'b1;
  endtask

  task automatic rd_pulse(output logic [15:0] dv, output logic ov);
    rd_n = 1'b0;
    tick(20);
    dv = db_out;
    ov = db_oe;
    rd_n = 1'b1;
    tick(10);
  endtask

  task automatic wr_pulse(input logic [15:0] v);
    db_in = v;
    wr_n = 1'b0;
    tick(10);
    wr_n = 1'b1;
    tick(6);
  endtask

  task automatic wait_eoc();
    for (int k = 0; k < 600; k++) begin
      if (eoc_n === 1'b0) break;
      tick(1);
    end
    chk("eoc_wait", {15'd0, eoc_n}, 16'h0000);
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; convst_n = 1'b1; cs_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; db_in = 16'h0000;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_eoc",   {15'd0, eoc_n}, 16'h0001);
    chk("rst_busy",  {15'd0, busy},  16'h0000);
    chk("rst_oe",    {15'd0, db_oe}, 16'h0000);
    chk("rst_dout",  db_out,         16'h0000);
    chk("rst_cfg",   cfg,            16'h0000);
    chk("rst_frame", frame_cnt,      16'h0000);

    conv_pulse();
    tick(2);
    chk("busy_t2",  {15'd0, busy},  16'h0000);
    tick(1);
    chk("busy_t3",  {15'd0, busy},  16'h0001);
    tick(398);
    chk("eoc_t401", {15'd0, eoc_n}, 16'h0001);
    tick(1);
    chk("eoc_t402", {15'd0, eoc_n}, 16'h0000);
    chk("busy_eoc", {15'd0, busy},  16'h0000);
    chk("frame1",   frame_cnt,      16'h0001);

    cs_n = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ch;
      ch = 3'(i);
      rd_pulse(d, oe);
      chk("rd_seq", d, {ch, 13'd1});
      chk("rd_oe", {15'd0, oe}, 16'h0001);
      if (i == 0) chk("eoc_rd1", {15'd0, eoc_n}, 16'h0001);
    end
    chk("oe_idle", {15'd0, db_oe}, 16'h0000);
    rd_pulse(d, oe);
    chk("extra_rd1", d, 16'h0001);
    rd_pulse(d, oe);
    chk("extra_rd2", d, 16'h0001);

    wr_pulse(16'h0001);
    chk("cfg_wr",   cfg,    16'h0001);
    chk("dout_inv", db_out, 16'h8001);
    rd_n = 1'b0;
    wr_n = 1'b0;
    tick(6);
    chk("rdwr_oe", {15'd0, db_oe}, 16'h0000);
    rd_n = 1'b1;
    wr_n = 1'b1;
    tick(6);

    conv_pulse();
    wait_eoc();
    chk("frame2", frame_cnt, 16'h0002);
    rd_pulse(d, oe);
    chk("f2_ch0", d, 16'h8002);
    rd_pulse(d, oe);
    chk("f2_ch1", d, 16'hA002);
    rd_pulse(d, oe);
    chk("f2_ch2", d, 16'hC002);

    wr_pulse(16'h0000);
    chk("cfg_clr", cfg, 16'h0000);
    conv_pulse();
    tick(4);
    chk("abort_busy", {15'd0, busy},  16'h0001);
    chk("abort_eoc",  {15'd0, eoc_n}, 16'h0001);
    wait_eoc();
    chk("frame3", frame_cnt, 16'h0003);
    rd_pulse(d, oe);
    chk("f3_ch0", d, 16'h0003);
    rd_pulse(d, oe);
    chk("f3_ch1", d, 16'h2003);

    wr_pulse(16'h0001);
    conv_pulse();
    tick(103);
    chk("pre_rst_busy", {15'd0, busy}, 16'h0001);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_eoc",   {15'd0, eoc_n}, 16'h0001);
    chk("mid_rst_busy",  {15'd0, busy},  16'h0000);
    chk("mid_rst_oe",    {15'd0, db_oe}, 16'h0000);
    chk("mid_rst_dout",  db_out,         16'h0000);
    chk("mid_rst_cfg",   cfg,            16'h0000);
    chk("mid_rst_frame", frame_cnt,      16'h0000);
    rst = 1'b0;
    tick(2);
    conv_pulse();
    wait_eoc();
    chk("frame_after_rst", frame_cnt, 16'h0001);
    rd_pulse(d, oe);
    chk("rst_f1_ch0", d, 16'h0001);

    conv_pulse();
    tick(100);
    convst_n = 1'b0;
    tick(10);
    convst_n = 1'b1;
    tick(291);
    chk("dbl_eoc401", {15'd0, eoc_n}, 16'h0001);
    tick(1);
    chk("dbl_eoc402", {15'd0, eoc_n}, 16'h0000);
    chk("dbl_frame",  frame_cnt,      16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
